// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the two-requester signed multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned OpWidth   = 64;
  localparam int unsigned ProdWidth = 128;
  localparam int unsigned CntWidth  = 2;

  typedef logic [0:0] req_id_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/mul_core.sv
// Combinational signed 64x64 -> 128 multiplier.
module mul_core
  import mul_arb_pkg::*;
(
  input  logic signed [OpWidth-1:0]   a,
  input  logic signed [OpWidth-1:0]   b,
  output logic signed [ProdWidth-1:0] product
);

  // All operands signed, so both are sign-extended to the 128-bit context.
  assign product = a * b;

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of a shared signed multiplier with LAT execute cycles.
// Define MUL_ARB_RR_EN for round-robin arbitration; fixed priority (req0 first) otherwise.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OpWidth-1:0]   req0_a,
  input  logic [OpWidth-1:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OpWidth-1:0]   req1_a,
  input  logic [OpWidth-1:0]   req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [ProdWidth-1:0] rsp_product,
  output logic                 busy
);

  localparam logic [CntWidth-1:0] CntInit = CntWidth'(LAT - 1);

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [OpWidth-1:0]   a_q, a_d, b_q, b_d;
  req_id_t              id_q, id_d;
  logic [ProdWidth-1:0] prod_q, prod_d;
  req_id_t              rsp_id_q, rsp_id_d;
  logic [ProdWidth-1:0] product;
  logic                 gnt;
  req_id_t              gnt_id;

`ifdef MUL_ARB_RR_EN
  req_id_t last_grant_q, last_grant_d;
`endif

  mul_core u_mul_core (
    .a       (a_q),
    .b       (b_q),
    .product (product)
  );

  always_comb begin
`ifdef MUL_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = req0_valid ? req_id_t'(1'b0) : req_id_t'(1'b1);
    end
`else
    gnt_id = req0_valid ? req_id_t'(1'b0) : req_id_t'(1'b1);
`endif
    // Ready is suppressed during reset so nothing looks accepted that will be dropped.
    gnt = (state_q == StIdle) && (req0_valid || req1_valid) && !rst;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    prod_d     = prod_q;
    rsp_id_d   = rsp_id_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
`ifdef MUL_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      StIdle: begin
        if (gnt) begin
          req0_ready = (gnt_id == 1'b0);
          req1_ready = (gnt_id == 1'b1);
          a_d        = (gnt_id == 1'b1) ? req1_a : req0_a;
          b_d        = (gnt_id == 1'b1) ? req1_b : req0_b;
          id_d       = gnt_id;
          cnt_d      = CntInit;
          state_d    = StExec;
`ifdef MUL_ARB_RR_EN
          last_grant_d = gnt_id;
`endif
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          prod_d   = product;
          rsp_id_d = id_q;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      prod_q   <= '0;
      rsp_id_q <= '0;
`ifdef MUL_ARB_RR_EN
      last_grant_q <= req_id_t'(1'b1);
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      prod_q   <= prod_d;
      rsp_id_q <= rsp_id_d;
`ifdef MUL_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign rsp_product = prod_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: LAT=1 instance for function/arbitration, LAT=3 for latency/reset.
module tb_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst, rst3;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [63:0]  req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [127:0] rsp_product;
  logic         l3_req0_ready, l3_req1_ready, l3_rsp_valid, l3_rsp_id, l3_busy;
  logic [127:0] l3_rsp_product;

  int   ntests = 0;
  int   nfail  = 0;
  logic exp_last;

`ifdef MUL_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  always #5 clk = ~clk;

  mul_arbiter #(.LAT(1)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  mul_arbiter #(.LAT(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst3),
    .req0_valid  (req0_valid),
    .req0_ready  (l3_req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (l3_req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (l3_rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (l3_rsp_id),
    .rsp_product (l3_rsp_product),
    .busy        (l3_busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sign-magnitude reference product.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  ua, ub;
    logic [127:0] up;
    ua = a[63] ? (~a + 64'd1) : a;
    ub = b[63] ? (~b + 64'd1) : b;
    up = {64'd0, ua} * {64'd0, ub};
    return (a[63] ^ b[63]) ? (~up + 128'd1) : up;
  endfunction

  function automatic logic ref_grant(input logic v0, input logic v1);
    if (v0 && v1) return RrEn ? ~exp_last : 1'b0;
    return v0 ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 64'h8000_0000_0000_0000;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rst3 = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_l3_ready0", l3_req0_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_product", rsp_product, 128'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    exp_last = 1'b1;
  endtask

  // One transaction on the LAT=1 instance; hold = RESP cycles with rsp_ready low.
  task automatic op1(input logic v0, input logic v1, input logic [63:0] a0, input logic [63:0] b0,
                     input logic [63:0] a1, input logic [63:0] b1, input int hold);
    logic         g;
    logic [127:0] ep;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp_ready = (hold == 0);
    #1;
    g  = ref_grant(v0, v1);
    ep = g ? ref_mul(a1, b1) : ref_mul(a0, b0);
    exp_last = g;
    check("idle_ready0", req0_ready, !g);
    check("idle_ready1", req1_ready, g);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    // Garbage requests while busy: must not be accepted nor alter the result.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = rnd_op(); req0_b = rnd_op(); req1_a = rnd_op(); req1_b = rnd_op();
    #1;
    check("exec_ready0", req0_ready, 1'b0);
    check("exec_ready1", req1_ready, 1'b0);
    check("exec_rsp_valid", rsp_valid, 1'b0);
    check("exec_busy", busy, 1'b1);
    @(negedge clk);
    check("resp_valid", rsp_valid, 1'b1);
    check("resp_product", rsp_product, ep);
    check("resp_id", rsp_id, g);
    check("resp_ready0", req0_ready, 1'b0);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_product", rsp_product, ep);
      check("hold_id", rsp_id, g);
      check("hold_ready1", req1_ready, 1'b0);
      if (i == hold) rsp_ready = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("done_busy", busy, 1'b0);
    check("done_rsp_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    logic         seen, g, rv;
    int           waited, vsel;
    logic [127:0] ep;
    rst = 1'b1; rst3 = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    exp_last = 1'b1;

    do_reset();
    op1(1'b1, 1'b0, 64'd10, 64'd5, 64'd0, 64'd0, 0);
    op1(1'b0, 1'b1, 64'd0, 64'd0, -64'sd8, 64'd6, 0);
    op1(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 0);
    op1(1'b1, 1'b1, -64'sd12, -64'sd4, 64'd3, 64'd3, 0);
    op1(1'b0, 1'b1, 64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, -64'sd3, 5);
    for (int k = 0; k < 24; k++) begin
      vsel = $urandom_range(1, 3);
      op1(vsel[0], vsel[1], rnd_op(), rnd_op(), rnd_op(), rnd_op(), $urandom_range(0, 2));
    end

    // Both requesters continuously valid, consumer always ready.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_a = rnd_op(); req0_b = rnd_op(); req1_a = rnd_op(); req1_b = rnd_op();
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      waited = 0;
      while (!seen && waited < 10) begin
        #1;
        if (req0_ready || req1_ready) seen = 1'b1;
        else begin
          @(negedge clk);
          waited++;
        end
      end
      check("cont_grant_seen", seen, 1'b1);
      if (seen) begin
        g = ref_grant(1'b1, 1'b1);
        exp_last = g;
        check("cont_grant1", req1_ready, g);
        check("cont_grant0", req0_ready, !g);
        if (k > 0) check("cont_issue_gap", waited + 1, 3);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("cont_drain_busy", busy, 1'b0);

    // LAT=3 instance: latency, then reset while executing.
    @(negedge clk);
    rst = 1'b1; rst3 = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 64'd7; req0_b = -64'sd9; rsp_ready = 1'b1;
    ep = ref_mul(64'd7, -64'sd9);
    #1;
    check("l3_grant0", l3_req0_ready, 1'b1);
    check("l3_grant1", l3_req1_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      check("l3_exec_valid", l3_rsp_valid, 1'b0);
      check("l3_exec_busy", l3_busy, 1'b1);
    end
    @(negedge clk);
    check("l3_resp_valid", l3_rsp_valid, 1'b1);
    check("l3_resp_product", l3_rsp_product, ep);
    check("l3_resp_id", l3_rsp_id, 1'b0);
    @(negedge clk);
    check("l3_done_busy", l3_busy, 1'b0);

    req1_valid = 1'b1; req1_a = 64'd11; req1_b = 64'd13;
    #1;
    check("l3_grant_r1", l3_req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    check("l3_mid_busy", l3_busy, 1'b1);
    rst3 = 1'b1; req0_valid = 1'b1;
    #1;
    check("l3_rst_ready0", l3_req0_ready, 1'b0);
    @(negedge clk);
    check("l3_rst_busy", l3_busy, 1'b0);
    check("l3_rst_valid", l3_rsp_valid, 1'b0);
    check("l3_rst_id", l3_rsp_id, 1'b0);
    check("l3_rst_product", l3_rsp_product, 128'd0);
    rst3 = 1'b0; req0_valid = 1'b0;
    rv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      rv = rv | l3_rsp_valid;
    end
    check("l3_no_dropped_rsp", rv, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
